// File: rtl/lsu_axi_master_if.sv
// rtl/lsu_axi_master_if.sv - AXI-Lite-style bus bundle between lsu_axi_master and its slave
interface lsu_axi_master_if #(
  parameter int AXI_AWIDTH = 4
);
  logic [AXI_AWIDTH-1:0] AXI_AWADDR;
  logic                  AXI_AWVALID;
  logic                  AXI_AWREADY;
  logic [31:0]           AXI_WDATA;
  logic [3:0]            AXI_WSTRB;
  logic                  AXI_WVALID;
  logic                  AXI_WREADY;
  logic [1:0]            AXI_BRESP;
  logic                  AXI_BVALID;
  logic                  AXI_BREADY;
  logic [AXI_AWIDTH-1:0] AXI_ARADDR;
  logic                  AXI_ARVALID;
  logic                  AXI_ARREADY;
  logic [31:0]           AXI_RDATA;
  logic [1:0]            AXI_RRESP;
  logic                  AXI_RVALID;
  logic                  AXI_RREADY;

  modport master (
    output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
    output AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
    input  AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
  );

  modport slave (
    input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
    input  AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
    output AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
  );
endinterface

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - RV32I load/store unit issuing single-beat AXI-Lite-style transfers
module lsu_axi_master #(
  parameter int AXI_AWIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        AXI_ACLK,
  input  logic        AXI_ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  lsu_axi_master_if.master axi
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA} state_t;

  state_t                r_state, w_state;
  logic                  r_awvalid, w_awvalid, r_wvalid, w_wvalid, r_bready, w_bready;
  logic                  r_arvalid, w_arvalid, r_rready, w_rready;
  logic [AXI_AWIDTH-1:0] r_awaddr, w_awaddr, r_araddr, w_araddr;
  logic [31:0]           r_wdata, w_wdata;
  logic [3:0]            r_wstrb, w_wstrb;
  logic                  r_resp_valid, w_resp_valid, r_resp_err, w_resp_err;
  logic [31:0]           r_resp_rdata, w_resp_rdata;
  logic [2:0]            r_funct3, w_funct3;
  logic [1:0]            r_lo, w_lo;
  logic [15:0]           r_wdog, w_wdog;
  logic [16:0]           w_wdog_inc;
  logic                  w_legal, w_final;
  logic [31:0]           w_st_data, w_rshift_b, w_rshift_h, w_load;
  logic [3:0]            w_st_strb;
  logic                  w_unused;

  assign w_unused = ^req_addr[31:AXI_AWIDTH+2];

  always_comb begin
    case (req_funct3)
      3'b000, 3'b100: w_legal = 1'b1;
      3'b001, 3'b101: w_legal = ~req_addr[0];
      3'b010:         w_legal = (req_addr[1:0] == 2'b00);
      default:        w_legal = 1'b0;
    endcase
  end

  // Narrow stores replicate the datum across the word so the strobe alone picks the lane
  always_comb begin
    w_st_data = req_wdata;
    w_st_strb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        w_st_data = {4{req_wdata[7:0]}};
        w_st_strb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_st_data = {2{req_wdata[15:0]}};
        w_st_strb = 4'b0011 << req_addr[1:0];
      end
      default: begin
      end
    endcase
  end

  assign w_rshift_b = axi.AXI_RDATA >> {r_lo, 3'b000};
  assign w_rshift_h = axi.AXI_RDATA >> {r_lo[1], 4'b0000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_rshift_b[7]}}, w_rshift_b[7:0]};
      3'b100:  w_load = {24'd0, w_rshift_b[7:0]};
      3'b001:  w_load = {{16{w_rshift_h[15]}}, w_rshift_h[15:0]};
      3'b101:  w_load = {16'd0, w_rshift_h[15:0]};
      default: w_load = axi.AXI_RDATA;
    endcase
  end

  assign w_wdog_inc = {1'b0, r_wdog} + 17'd1;

  always_comb begin
    w_state      = r_state;
    w_awvalid    = r_awvalid;
    w_wvalid     = r_wvalid;
    w_bready     = r_bready;
    w_arvalid    = r_arvalid;
    w_rready     = r_rready;
    w_awaddr     = r_awaddr;
    w_araddr     = r_araddr;
    w_wdata      = r_wdata;
    w_wstrb      = r_wstrb;
    w_funct3     = r_funct3;
    w_lo         = r_lo;
    w_wdog       = r_wdog;
    w_resp_valid = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_rdata = 32'd0;
    w_final      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_wdog   = 16'd0;
          w_funct3 = req_funct3;
          w_lo     = req_addr[1:0];
          if (!w_legal) begin
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
          end else if (req_we) begin
            w_state   = S_WRITE;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_awaddr  = req_addr[AXI_AWIDTH+1:2];
            w_wdata   = w_st_data;
            w_wstrb   = w_st_strb;
          end else begin
            w_state   = S_READ;
            w_arvalid = 1'b1;
            w_rready  = 1'b1;
            w_araddr  = req_addr[AXI_AWIDTH+1:2];
          end
        end
      end
      S_WRITE: begin
        if (axi.AXI_AWREADY) w_awvalid = 1'b0;
        if (axi.AXI_WREADY)  w_wvalid  = 1'b0;
        if (!w_awvalid && !w_wvalid) begin
          w_state  = S_WRESP;
          w_bready = 1'b1;
        end
      end
      S_WRESP: begin
        if (axi.AXI_BVALID) begin
          w_bready     = 1'b0;
          w_resp_valid = 1'b1;
          w_resp_err   = |axi.AXI_BRESP;
          w_final      = 1'b1;
          w_state      = S_IDLE;
        end
      end
      S_READ: begin
        if (axi.AXI_ARREADY) begin
          w_arvalid = 1'b0;
          w_state   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (axi.AXI_RVALID) begin
          w_rready     = 1'b0;
          w_resp_valid = 1'b1;
          w_resp_err   = |axi.AXI_RRESP;
          w_resp_rdata = (|axi.AXI_RRESP) ? 32'd0 : w_load;
          w_final      = 1'b1;
          w_state      = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // A completing B/R handshake wins over a watchdog expiry on the same edge
    if (r_state != S_IDLE) begin
      w_wdog = w_wdog_inc[15:0];
      if (!w_final && (w_wdog_inc == 17'(TIMEOUT_CYCLES))) begin
        w_state      = S_IDLE;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_resp_valid = 1'b1;
        w_resp_err   = 1'b1;
        w_resp_rdata = 32'd0;
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state      <= S_IDLE;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_funct3     <= 3'd0;
      r_lo         <= 2'd0;
      r_wdog       <= 16'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_state      <= w_state;
      r_awvalid    <= w_awvalid;
      r_wvalid     <= w_wvalid;
      r_bready     <= w_bready;
      r_arvalid    <= w_arvalid;
      r_rready     <= w_rready;
      r_awaddr     <= w_awaddr;
      r_araddr     <= w_araddr;
      r_wdata      <= w_wdata;
      r_wstrb      <= w_wstrb;
      r_funct3     <= w_funct3;
      r_lo         <= w_lo;
      r_wdog       <= w_wdog;
      r_resp_valid <= w_resp_valid;
      r_resp_err   <= w_resp_err;
      r_resp_rdata <= w_resp_rdata;
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign resp_valid      = r_resp_valid;
  assign resp_err        = r_resp_err;
  assign resp_rdata      = r_resp_rdata;
  assign axi.AXI_AWADDR  = r_awaddr;
  assign axi.AXI_AWVALID = r_awvalid;
  assign axi.AXI_WDATA   = r_wdata;
  assign axi.AXI_WSTRB   = r_wstrb;
  assign axi.AXI_WVALID  = r_wvalid;
  assign axi.AXI_BREADY  = r_bready;
  assign axi.AXI_ARADDR  = r_araddr;
  assign axi.AXI_ARVALID = r_arvalid;
  assign axi.AXI_RREADY  = r_rready;
endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - table-driven and randomized checks of lsu_axi_master against a behavioural model
module tb_lsu_axi_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  lsu_axi_master_if #(.AXI_AWIDTH(4)) axi ();

  lsu_axi_master #(.AXI_AWIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi(axi)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  rsp;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] model_mem [16];
  logic [31:0] slave_mem [16];
  vec_t        vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int f_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit f_legal(input logic [2:0] f3, input logic [31:0] a);
    int sz = f_size(f3);
    if (sz == 0) return 1'b0;
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] word = model_mem[a[5:2]];
    logic [31:0] v;
    int          lo = int'(a[1:0]);
    case (f_size(f3))
      1: begin
        v = (word >> (8 * lo)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      2: begin
        v = (word >> (16 * (lo / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] f_st_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f_size(f3))
      1:       return (wd & 32'hFF) * 32'h01010101;
      2:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] f_st_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f_size(f3))
      1:       return 4'(1 << int'(a[1:0]));
      2:       return 4'(3 << int'(a[1:0]));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic clear_slave();
    axi.AXI_AWREADY = 1'b0; axi.AXI_WREADY = 1'b0; axi.AXI_BVALID = 1'b0; axi.AXI_BRESP = 2'b00;
    axi.AXI_ARREADY = 1'b0; axi.AXI_RVALID = 1'b0; axi.AXI_RRESP = 2'b00; axi.AXI_RDATA = 32'd0;
  endtask

  // Called at a falling edge; drives one request and acts as the slave until resp_valid
  task automatic txn(input vec_t v, input bit use_model);
    bit          legal, got, unstable;
    bit          aw_seen, w_seen, ar_seen, b_done, r_done;
    int          c, aw_w, w_w, b_w, ar_w, r_w, aw_hs, w_hs, ar_hs;
    logic        exp_err, g_err, g_rr;
    logic [31:0] exp_rdata, g_rdata, f_wdata;
    logic [3:0]  f_wstrb;
    logic [3:0]  f_awaddr, f_araddr;
    logic [4:0]  g_idle;
    legal = f_legal(v.f3, v.addr);
    if (use_model) begin
      exp_err   = !legal || (v.rsp != 2'b00);
      exp_rdata = (exp_err || v.we) ? 32'd0 : f_load(v.f3, v.addr);
    end else begin
      exp_err   = v.exp_err;
      exp_rdata = v.exp_rdata;
    end
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    got = 0; unstable = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; b_done = 0; r_done = 0;
    c = 0; aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
    f_wdata = 32'd0; f_wstrb = 4'd0; f_awaddr = 4'd0; f_araddr = 4'd0;
    g_err = 1'b0; g_rr = 1'b0; g_rdata = 32'd0; g_idle = 5'd0;
    while (!got && c < 40) begin
      if (resp_valid) begin
        got = 1; g_err = resp_err; g_rdata = resp_rdata; g_rr = req_ready;
        g_idle = {axi.AXI_AWVALID, axi.AXI_WVALID, axi.AXI_BREADY, axi.AXI_ARVALID, axi.AXI_RREADY};
      end else begin
        if (b_done) axi.AXI_BVALID = 1'b0;
        else if (aw_hs > 0 && w_hs > 0) begin
          if (b_w >= v.b_d) begin axi.AXI_BVALID = 1'b1; axi.AXI_BRESP = v.rsp; end
          else b_w++;
        end
        if (axi.AXI_BVALID && axi.AXI_BREADY && !b_done) begin
          b_done = 1;
          if (v.rsp == 2'b00) slave_mem[f_awaddr] = f_merge(slave_mem[f_awaddr], f_wdata, f_wstrb);
        end
        if (r_done) axi.AXI_RVALID = 1'b0;
        else if (ar_hs > 0) begin
          if (r_w >= v.r_d) begin
            axi.AXI_RVALID = 1'b1; axi.AXI_RRESP = v.rsp; axi.AXI_RDATA = slave_mem[f_araddr];
          end else r_w++;
        end
        if (axi.AXI_RVALID && axi.AXI_RREADY) r_done = 1;
        if (axi.AXI_AWVALID) begin
          if (!aw_seen) begin aw_seen = 1; f_awaddr = axi.AXI_AWADDR; end
          else if (axi.AXI_AWADDR !== f_awaddr) unstable = 1;
          if (aw_w >= v.aw_d) begin axi.AXI_AWREADY = 1'b1; aw_hs++; end
          else begin axi.AXI_AWREADY = 1'b0; aw_w++; end
        end else axi.AXI_AWREADY = 1'b0;
        if (axi.AXI_WVALID) begin
          if (!w_seen) begin w_seen = 1; f_wdata = axi.AXI_WDATA; f_wstrb = axi.AXI_WSTRB; end
          else if (axi.AXI_WDATA !== f_wdata || axi.AXI_WSTRB !== f_wstrb) unstable = 1;
          if (w_w >= v.w_d) begin axi.AXI_WREADY = 1'b1; w_hs++; end
          else begin axi.AXI_WREADY = 1'b0; w_w++; end
        end else axi.AXI_WREADY = 1'b0;
        if (axi.AXI_ARVALID) begin
          if (!ar_seen) begin ar_seen = 1; f_araddr = axi.AXI_ARADDR; end
          else if (axi.AXI_ARADDR !== f_araddr) unstable = 1;
          if (ar_w >= v.ar_d) begin axi.AXI_ARREADY = 1'b1; ar_hs++; end
          else begin axi.AXI_ARREADY = 1'b0; ar_w++; end
        end else axi.AXI_ARREADY = 1'b0;
        @(negedge clk);
        c++;
      end
    end
    clear_slave();
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL resp_wait: no resp_valid within %0d cycles for addr %h", c, v.addr);
    end else begin
      chk("resp_err", {31'd0, g_err}, {31'd0, exp_err});
      chk("resp_rdata", g_rdata, exp_rdata);
      chk("valids_low_at_resp", {27'd0, g_idle}, 32'd0);
      chk("req_ready_at_resp", {31'd0, g_rr}, 32'd1);
      chk("aw_issued", {31'd0, aw_seen}, {31'd0, legal && v.we});
      chk("ar_issued", {31'd0, ar_seen}, {31'd0, legal && !v.we});
      chk("stable_while_valid", {31'd0, unstable}, 32'd0);
      if (v.exp_lat >= 0) chk("latency", c, v.exp_lat);
      if (legal && v.we) begin
        chk("awaddr", {28'd0, f_awaddr}, {28'd0, v.addr[5:2]});
        chk("wdata", f_wdata, f_st_data(v.f3, v.wd));
        chk("wstrb", {28'd0, f_wstrb}, {28'd0, f_st_strb(v.f3, v.addr)});
        chk("aw_once", aw_hs, 1);
        chk("w_once", w_hs, 1);
        if (v.rsp == 2'b00)
          model_mem[v.addr[5:2]] = f_merge(model_mem[v.addr[5:2]], f_st_data(v.f3, v.wd), f_st_strb(v.f3, v.addr));
      end
      if (legal && !v.we) chk("araddr", {28'd0, f_araddr}, {28'd0, v.addr[5:2]});
    end
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 3'b000, 32'h6, 32'hAB,       0, 0, 0, 0, 0,    2'b00, 1'b0, 32'h0,        2};
    vecs[1]  = '{1'b0, 3'b000, 32'h9, 32'h0,        0, 0, 0, 0, 0,    2'b00, 1'b0, 32'h0000007F, 2};
    vecs[2]  = '{1'b0, 3'b001, 32'hA, 32'h0,        0, 0, 0, 1, 1,    2'b00, 1'b0, 32'hFFFF80FF, -1};
    vecs[3]  = '{1'b0, 3'b101, 32'hA, 32'h0,        0, 0, 0, 2, 0,    2'b00, 1'b0, 32'h000080FF, -1};
    vecs[4]  = '{1'b0, 3'b010, 32'h8, 32'h0,        0, 0, 0, 0, 2,    2'b00, 1'b0, 32'h80FF7F01, -1};
    vecs[5]  = '{1'b0, 3'b100, 32'hB, 32'h0,        0, 0, 0, 0, 0,    2'b00, 1'b0, 32'h00000080, -1};
    vecs[6]  = '{1'b0, 3'b000, 32'hB, 32'h0,        0, 0, 0, 0, 0,    2'b00, 1'b0, 32'hFFFFFF80, -1};
    vecs[7]  = '{1'b1, 3'b010, 32'h5, 32'h1234,     0, 0, 0, 0, 0,    2'b00, 1'b1, 32'h0,        0};
    vecs[8]  = '{1'b0, 3'b001, 32'h3, 32'h0,        0, 0, 0, 0, 0,    2'b00, 1'b1, 32'h0,        0};
    vecs[9]  = '{1'b0, 3'b011, 32'h8, 32'h0,        0, 0, 0, 0, 0,    2'b00, 1'b1, 32'h0,        0};
    vecs[10] = '{1'b1, 3'b010, 32'hC, 32'h12345678, 0, 3, 2, 0, 0,    2'b00, 1'b0, 32'h0,        7};
    vecs[11] = '{1'b0, 3'b010, 32'hC, 32'h0,        0, 0, 0, 0, 0,    2'b00, 1'b0, 32'h12345678, 2};
    vecs[12] = '{1'b1, 3'b001, 32'h2, 32'hBEEF,     1, 0, 1, 0, 0,    2'b10, 1'b1, 32'h0,        -1};
    vecs[13] = '{1'b0, 3'b010, 32'h0, 32'h0,        0, 0, 0, 0, 0,    2'b10, 1'b1, 32'h0,        -1};
    vecs[14] = '{1'b0, 3'b010, 32'h4, 32'h0,        0, 0, 0, 1000, 0, 2'b00, 1'b1, 32'h0,        TO};
    vecs[15] = '{1'b0, 3'b010, 32'h4, 32'h0,        0, 0, 0, 0, 0,    2'b00, 1'b0, 32'h00AB0000, 2};

    for (int i = 0; i < 16; i++) begin model_mem[i] = 32'd0; slave_mem[i] = 32'd0; end
    model_mem[2] = 32'h80FF7F01;
    slave_mem[2] = 32'h80FF7F01;
    clear_slave();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_valids", {27'd0, axi.AXI_AWVALID, axi.AXI_WVALID, axi.AXI_BREADY, axi.AXI_ARVALID, axi.AXI_RREADY}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) txn(vecs[i], 1'b0);

    // Back-to-back illegal requests: each answered the next cycle with no bubble
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1;
    @(posedge clk); @(negedge clk);
    chk("b2b_first_resp", {30'd0, resp_valid, resp_err}, 32'd3);
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    req_addr = 32'h2;
    @(posedge clk); @(negedge clk);
    chk("b2b_second_resp", {30'd0, resp_valid, resp_err}, 32'd3);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b2b_quiet", {31'd0, resp_valid}, 32'd0);

    // Reset while waiting for read data aborts silently
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    axi.AXI_ARREADY = axi.AXI_ARVALID;
    @(posedge clk); @(negedge clk);
    axi.AXI_ARREADY = 1'b0;
    chk("rdata_wait_rready", {31'd0, axi.AXI_RREADY}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valids", {27'd0, axi.AXI_AWVALID, axi.AXI_WVALID, axi.AXI_BREADY, axi.AXI_ARVALID, axi.AXI_RREADY}, 32'd0);
    chk("mid_rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("mid_rst_addr", {24'd0, axi.AXI_AWADDR, axi.AXI_ARADDR}, 32'd0);
    chk("mid_rst_wdata", axi.AXI_WDATA, 32'd0);
    chk("mid_rst_wstrb", {28'd0, axi.AXI_WSTRB}, 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    begin
      bit seen = 0;
      repeat (4) begin @(negedge clk); if (resp_valid) seen = 1; end
      chk("no_resp_after_abort", {31'd0, seen}, 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      slave_mem[i] = model_mem[i];
    end
    for (int n = 0; n < 80; n++) begin
      v.we = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wd = $urandom;
      v.aw_d = int'($urandom_range(0, 2));
      v.w_d  = int'($urandom_range(0, 2));
      v.b_d  = int'($urandom_range(0, 2));
      v.ar_d = int'($urandom_range(0, 2));
      v.r_d  = int'($urandom_range(0, 2));
      v.rsp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      v.exp_err = 1'b0;
      v.exp_rdata = 32'd0;
      v.exp_lat = -1;
      txn(v, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 4: AXI word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit per transaction, 1..65535.
REQ-003 SHALL have AXI_ACLK  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have req_valid  in  1  core load/store request.
REQ-006 SHALL have req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
REQ-007 SHALL have req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
REQ-009 SHALL have req_addr  in  32  byte address.
REQ-010 SHALL have req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores/errors.
REQ-013 SHALL have resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, non-OKAY response, or timeout.
REQ-014 SHALL have AXI_AWADDR/AXI_ARADDR  out  AXI_AWIDTH  word address = req_addr[AXI_AWIDTH+1:2].
REQ-015 SHALL have AXI_AWVALID, AXI_WVALID, AXI_BREADY, AXI_ARVALID, AXI_RREADY  out  1 each; AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_ARREADY, AXI_RVALID  in  1 each.
REQ-016 SHALL have AXI_WDATA  out  32, AXI_WSTRB  out  4, AXI_BRESP  in  2, AXI_RDATA  in  32, AXI_RRESP  in  2.

Function
REQ-017 SHALL implement FSM IDLE, WRITE, WRESP, READ, RDATA; request fields registered on acceptance.
REQ-018 Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) or illegal funct3 SHALL issue no AXI traffic: resp_valid=1, resp_err=1 on the cycle after acceptance, FSM stays IDLE.
REQ-019 IDLE->WRITE on legal store: AWVALID and WVALID asserted together next cycle; each deasserted the cycle after its own VALID&READY edge; WRITE->WRESP when both done.
REQ-020 Store lanes: B replicates wdata[7:0] to all bytes, WSTRB=0001<<addr[1:0]; H replicates wdata[15:0], WSTRB=0011<<addr[1:0]; W WSTRB=1111.
REQ-021 WRESP SHALL hold BREADY=1; on BVALID: BREADY drops, resp_valid pulses, resp_err=(BRESP!=00), ->IDLE.
REQ-022 IDLE->READ on legal load: ARVALID=1 and RREADY=1 asserted together; ARVALID drops after AR handshake (->RDATA); RREADY stays high until R handshake.
REQ-023 On R handshake: RREADY drops, byte/half lane selected by addr[1:0], sign-extended (B,H) or zero-extended (BU,HU), resp_err=(RRESP!=00), resp_rdata=0 on error, resp_valid pulses, ->IDLE.
REQ-024 AW/W/B/AR/R handshake SHALL accept READY already high in the first VALID cycle (zero-wait) and any number of wait cycles.
REQ-025 Watchdog counter SHALL reset on acceptance, count each non-IDLE cycle; reaching TIMEOUT_CYCLES SHALL drop all VALID/READY, pulse resp_valid with resp_err=1, ->IDLE.
REQ-026 req_ready SHALL be high in the resp_valid cycle; back-to-back requests accepted with no bubble.
REQ-027 Handshake-channel outputs (ADDR, WDATA, WSTRB) SHALL stay stable while their VALID is high.

Reset
REQ-028 AXI_ARESET high at an edge SHALL force IDLE, all VALID/READY=0, resp_valid=0, resp_err=0, resp_rdata=0, AXI_AWADDR/ARADDR/WDATA/WSTRB=0, watchdog=0, aborting any transaction in flight with no resp_valid.

Verification
REQ-029 SB 0xAB to addr 0x6, zero-wait slave -> AWADDR=1, WDATA=0xABABABAB, WSTRB=0100, BRESP=00 -> resp_valid, resp_err=0.
REQ-030 Word 0x80FF7F01 at word addr 2; LB addr 0x9 -> 0xFFFFFF7F? no: byte1=0x7F -> 0x0000007F; LH 0xA -> 0xFFFF80FF; LHU 0xA -> 0x000080FF.
REQ-031 SW to 0x5 -> resp_valid+resp_err next cycle, AWVALID/ARVALID never asserted.
REQ-032 Slave AWREADY 3 cycles before WREADY, BVALID 2 cycles later -> AWVALID/WVALID drop independently, single resp_valid, data written once.
REQ-033 Slave never asserts ARREADY, TIMEOUT_CYCLES=8 -> resp_err=1 pulse after 8 cycles, ARVALID/RREADY=0, req_ready=1.
REQ-034 Reset asserted while in RDATA -> next cycle all outputs at reset values; RRESP=10 case separately -> resp_err=1, resp_rdata=0.
